// File: rtl/md_unit_pkg.sv
// Types and helpers shared by the md_unit multiply/divide unit.
`include "defines.vh"

package md_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = `MD_ST_IDLE,
    S_MUL  = `MD_ST_MUL,
    S_DIV  = `MD_ST_DIV,
    S_FIN  = `MD_ST_FIN
  } state_t;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  function automatic logic [`DATALENGTH-1:0] md_abs(input logic [`DATALENGTH-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic op_signed(input logic [1:0] op);
    return (op == `MD_MULT) || (op == `MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == `MD_DIV) || (op == `MD_DIVU);
  endfunction

endpackage

// File: rtl/defines.vh
// Shared op encodings, FSM state codes and datapath width for md_unit.
`ifndef MD_DEFINES_VH
`define MD_DEFINES_VH

`define DATALENGTH 32

`define MD_MULT  2'b00
`define MD_MULTU 2'b01
`define MD_DIV   2'b10
`define MD_DIVU  2'b11

`define MD_ST_IDLE 2'd0
`define MD_ST_MUL  2'd1
`define MD_ST_DIV  2'd2
`define MD_ST_FIN  2'd3

`endif

// File: rtl/md_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per i_step cycle.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [WIDTH:0]   w_shift, w_trial;

  // Dividend bits shift out of the quotient register into the remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dvd;
      r_dvs <= i_dvs;
    end else if (i_step) begin
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/md_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide.
// The divider is built only when MD_DIV_EN is defined; otherwise divide ops complete as no-ops.
`include "defines.vh"

module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = `DATALENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             whi,
  input  logic             wlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_isdiv, r_sa, r_sb, r_done, r_div_zero;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_prod, w_prod_nx, w_prod_fix;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_magA, w_magB;
  logic               w_accept, w_sa, w_sb, w_bzero;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_sa     = op_signed(op) & srcA[WIDTH-1];
  assign w_sb     = op_signed(op) & srcB[WIDTH-1];
  assign w_magA   = md_abs(srcA, w_sa);
  assign w_magB   = md_abs(srcB, w_sb);
  assign w_bzero  = (srcB == '0);

  // Multiplier sits in the low half of r_prod and shifts out as partial sums shift in.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nx  = {w_sum, r_prod[WIDTH-1:1]};
  assign w_prod_fix = (r_sa ^ r_sb) ? (~r_prod + 1'b1) : r_prod;

`ifdef MD_DIV_EN
  logic             r_bz;
  logic [WIDTH-1:0] w_quo, w_rem, w_quo_fix, w_rem_fix;

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_step (r_state == S_DIV),
    .i_dvd  (w_magA),
    .i_dvs  (w_magB),
    .o_quo  (w_quo),
    .o_rem  (w_rem)
  );

  // Remainder follows the dividend's sign; quotient is negative when signs differ.
  assign w_quo_fix = (r_sa ^ r_sb) ? (~w_quo + 1'b1) : w_quo;
  assign w_rem_fix = r_sa ? (~w_rem + 1'b1) : w_rem;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op_is_div(op))
            w_next = S_MUL;
`ifdef MD_DIV_EN
          else if (!w_bzero)
            w_next = S_DIV;
`endif
          else
            w_next = S_FIN;
        end
      end
      S_MUL: if (r_cnt == LAST_ITER) w_next = S_FIN;
`ifdef MD_DIV_EN
      S_DIV: if (r_cnt == LAST_ITER) w_next = S_FIN;
`endif
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_isdiv    <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MD_DIV_EN
      r_bz       <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_isdiv <= op_is_div(op);
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_mcand <= w_magA;
            r_prod  <= {{WIDTH{1'b0}}, w_magB};
`ifdef MD_DIV_EN
            r_bz    <= w_bzero;
`endif
          end else begin
            if (whi) r_hi <= srcA;
            if (wlo) r_lo <= srcA;
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nx;
          r_cnt  <= r_cnt + 1'b1;
        end
`ifdef MD_DIV_EN
        S_DIV: r_cnt <= r_cnt + 1'b1;
`endif
        S_FIN: begin
          r_done <= 1'b1;
          r_cnt  <= '0;
          if (!r_isdiv) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
`ifdef MD_DIV_EN
          else if (!r_bz) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_div_zero <= r_isdiv & r_bz;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized traffic against a cycle-count model.
`include "defines.vh"

module tb_md_unit;

  logic        clk, rst, start, whi, wlo;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .whi(whi), .wlo(wlo), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
    logic        dz;
    logic [5:0]  lat;
  } res_t;

  // Result of an operation from plain 64-bit arithmetic, plus how many busy cycles it takes.
  function automatic res_t model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, q, rm;
    logic [63:0] p;
    r = '0;
    r.wr = 1'b1;
    r.lat = 6'd33;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      `MD_MULT: begin
        p = sa * sb;
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      `MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      default: begin
`ifdef MD_DIV_EN
        if (b == 32'd0) begin
          r.wr = 1'b0; r.dz = 1'b1; r.lat = 6'd1;
        end else if (o == `MD_DIV) begin
          q = sa / sb; rm = sa % sb;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
`else
        r.wr = 1'b0; r.lat = 6'd1;
`endif
      end
    endcase
    return r;
  endfunction

  res_t        w_res, pend;
  logic        m_busy, m_done, m_dz;
  int          m_left;
  logic [31:0] m_hi, m_lo;

  assign w_res = model_op(op, srcA, srcB);

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_left <= 0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          pend   <= w_res;
          m_busy <= 1'b1;
          m_left <= int'(w_res.lat);
        end else begin
          if (whi) m_hi <= srcA;
          if (wlo) m_lo <= srcA;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz   <= pend.dz;
          if (pend.wr) begin
            m_hi <= pend.hi;
            m_lo <= pend.lo;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; srcA = '0; srcB = '0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int lat, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0; whi = 1'b0; wlo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    run_op(`MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    check("mult_lat", 64'(lat), 64'd34);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    check("mdl_mult_hi", 64'(m_hi), 64'hFFFF_FFFF);

    run_op(`MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    run_op(`MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat);
`ifdef MD_DIV_EN
    check("div_lat", 64'(lat), 64'd34);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mdl_div_lo", 64'(m_lo), 64'hFFFF_FFFD);
`else
    check("div_lat", 64'(lat), 64'd2);
    check("div_lo", 64'(lo), 64'hFFFF_FFFE);
    check("div_hi", 64'(hi), 64'h1);
`endif
    check("div_dz", 64'(div_zero), 64'd0);

    run_op(`MD_DIVU, 32'd7, 32'd2, lat);
`ifdef MD_DIV_EN
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);
`endif

    run_op(`MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
`ifdef MD_DIV_EN
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'h0);
`endif
    check("ovf_dz", 64'(div_zero), 64'd0);

    // Preload HI/LO, then divide by zero: HI/LO must survive.
    @(negedge clk); whi = 1'b1; srcA = 32'h11;
    @(negedge clk); whi = 1'b0; wlo = 1'b1; srcA = 32'h22;
    @(negedge clk); wlo = 1'b0; srcA = '0;
    check("pre_hi", 64'(hi), 64'h11);
    check("pre_lo", 64'(lo), 64'h22);
    run_op(`MD_DIVU, 32'd7, 32'd0, lat);
    check("dz_lat", 64'(lat), 64'd2);
`ifdef MD_DIV_EN
    check("dz_flag", 64'(div_zero), 64'd1);
`else
    check("dz_flag", 64'(div_zero), 64'd0);
`endif
    check("dz_hi", 64'(hi), 64'h11);
    check("dz_lo", 64'(lo), 64'h22);

    // Reset in the middle of a MULT.
    @(negedge clk); start = 1'b1; op = `MD_MULT; srcA = 32'd5; srcB = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check("mrst_nodone", 64'(ndone), 64'd0);

    // Second start and a whi strobe while busy are both ignored.
    @(negedge clk); start = 1'b1; op = `MD_MULTU; srcA = 32'd3; srcB = 32'd5;
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (c == 5);
      whi   = (c == 5);
      op    = (c == 5) ? `MD_MULT : `MD_MULTU;
      srcA  = (c == 5) ? 32'hDEAD_BEEF : 32'd0;
      srcB  = (c == 5) ? 32'd9 : 32'd0;
    end
    check("busy_ndone", 64'(ndone), 64'd1);
    check("busy_hi", 64'(hi), 64'd0);
    check("busy_lo", 64'(lo), 64'd15);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      srcA  = pick();
      srcB  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      whi   = ($urandom_range(0, 7) == 0);
      wlo   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; whi = 1'b0; wlo = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
